// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single MemoryUnit port (IDLE -> ISSUE -> WAIT).
// Defining BUS_ARBITER_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYCLES without bus_done.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [26:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m0_we,
  input  logic        m0_start,
  output logic [31:0] m0_q,
  output logic        m0_done,
  input  logic [26:0] m1_addr,
  input  logic [31:0] m1_data,
  input  logic        m1_we,
  input  logic        m1_start,
  output logic [31:0] m1_q,
  output logic        m1_done,
  output logic [26:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic [31:0] bus_q,
  input  logic        bus_done,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, next_state;

  logic        grant, last_grant;
  logic        p0_vld, p1_vld, p0_we, p1_we;
  logic [26:0] p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data;
  logic        req0, req1, sel, take, active, abort, complete;
  logic [26:0] sel_addr;
  logic [31:0] sel_data;
  logic        sel_we;

  assign active   = (state != IDLE);
  assign req0     = p0_vld | m0_start;
  assign req1     = p1_vld | m1_start;
  assign take     = (state == IDLE) & (req0 | req1);
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign sel      = req1 & (~req0 | ~last_grant);
  assign complete = active & (bus_done | abort);

  always_comb begin
    sel_addr = p0_vld ? p0_addr : m0_addr;
    sel_data = p0_vld ? p0_data : m0_data;
    sel_we   = p0_vld ? p0_we   : m0_we;
    if (sel) begin
      sel_addr = p1_vld ? p1_addr : m1_addr;
      sel_data = p1_vld ? p1_data : m1_data;
      sel_we   = p1_vld ? p1_we   : m1_we;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus_start  = 1'b0;
    unique case (state)
      IDLE:    if (take) next_state = ISSUE;
      ISSUE: begin
        bus_start  = 1'b1;
        next_state = complete ? IDLE : WAIT;
      end
      WAIT:    if (complete) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A start is only held when it is not consumed by this cycle's grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      p0_vld <= 1'b0; p0_addr <= '0; p0_data <= '0; p0_we <= 1'b0;
    end else if (take && !sel) begin
      p0_vld <= 1'b0;
    end else if (m0_start && !p0_vld && !(active && !grant)) begin
      p0_vld <= 1'b1; p0_addr <= m0_addr; p0_data <= m0_data; p0_we <= m0_we;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      p1_vld <= 1'b0; p1_addr <= '0; p1_data <= '0; p1_we <= 1'b0;
    end else if (take && sel) begin
      p1_vld <= 1'b0;
    end else if (m1_start && !p1_vld && !(active && grant)) begin
      p1_vld <= 1'b1; p1_addr <= m1_addr; p1_data <= m1_data; p1_we <= m1_we;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      bus_addr   <= '0;
      bus_data   <= '0;
      bus_we     <= 1'b0;
      m0_q       <= '0;
      m1_q       <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      if (take) begin
        grant      <= sel;
        last_grant <= sel;
        bus_addr   <= sel_addr;
        bus_data   <= sel_data;
        bus_we     <= sel_we;
      end else if (complete) begin
        bus_we <= 1'b0;
        if (grant) begin
          m1_done <= 1'b1;
          m1_q    <= bus_done ? bus_q : '0;
        end else begin
          m0_done <= 1'b1;
          m0_q    <= bus_done ? bus_q : '0;
        end
      end
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                 cnt <= '0;
    else if (active && !complete) cnt <= cnt + CW'(1);
    else                         cnt <= '0;
  end

  // A real completion in the same cycle always beats the abort.
  assign abort = active & ~bus_done & (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) bus_err <= 1'b0;
    else         bus_err <= abort;
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed plus random bench for bus_arbiter against a transaction-level requester/bus model.
module tb_bus_arbiter;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        ms[2];
  logic [26:0] ma[2];
  logic [31:0] md[2];
  logic        mw[2];
  logic [31:0] m0_q, m1_q, bus_data, bus_q;
  logic        m0_done, m1_done, bus_we, bus_start, bus_err, bus_done;
  logic [26:0] bus_addr;

  int errors = 0;
  int checks = 0;

  // Model: owner = requester whose transaction is on the bus (-1 none); age = cycles since bus_start.
  int          owner, last, age;
  bit          sv[2];
  logic [26:0] sa[2];
  logic [31:0] sd[2];
  bit          sw[2];
  logic        e_start, e_we, e_err;
  logic [26:0] e_addr;
  logic [31:0] e_data;
  logic        e_done[2];
  logic [31:0] e_q[2];

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nreset(nreset),
    .m0_addr(ma[0]), .m0_data(md[0]), .m0_we(mw[0]), .m0_start(ms[0]), .m0_q(m0_q), .m0_done(m0_done),
    .m1_addr(ma[1]), .m1_data(md[1]), .m1_we(mw[1]), .m1_start(ms[1]), .m1_q(m1_q), .m1_done(m1_done),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bus_start", bus_start, e_start);
    chk("bus_we", bus_we, e_we);
    chk("bus_addr", bus_addr, e_addr);
    chk("bus_data", bus_data, e_data);
    chk("bus_err", bus_err, e_err);
    chk("m0_done", m0_done, e_done[0]);
    chk("m1_done", m1_done, e_done[1]);
    chk("m0_q", m0_q, e_q[0]);
    chk("m1_q", m1_q, e_q[1]);
  endtask

  task automatic model_reset();
    owner = -1; last = 1; age = 0;
    for (int n = 0; n < 2; n++) begin
      sv[n] = 1'b0; e_done[n] = 1'b0; e_q[n] = '0;
    end
    e_start = 1'b0; e_we = 1'b0; e_err = 1'b0; e_addr = '0; e_data = '0;
  endtask

  task automatic capture(input int n);
    sv[n] = 1'b1; sa[n] = ma[n]; sd[n] = md[n]; sw[n] = mw[n];
  endtask

  // Applies this cycle's inputs to the model and yields the outputs expected next cycle.
  task automatic model_update();
    bit r[2];
    int g;
    e_start = 1'b0; e_err = 1'b0; e_done[0] = 1'b0; e_done[1] = 1'b0;
    if (owner >= 0) begin
      for (int n = 0; n < 2; n++)
        if (n != owner && ms[n] && !sv[n]) capture(n);
      if (bus_done) begin
        e_done[owner] = 1'b1; e_q[owner] = bus_q; e_we = 1'b0; owner = -1;
      end else if (TO_EN && age == TO - 1) begin
        e_done[owner] = 1'b1; e_q[owner] = '0; e_err = 1'b1; e_we = 1'b0; owner = -1;
      end else begin
        age++;
      end
    end else begin
      for (int n = 0; n < 2; n++) r[n] = sv[n] || ms[n];
      if (r[0] || r[1]) begin
        g = (r[0] && r[1]) ? 1 - last : (r[1] ? 1 : 0);
        if (sv[g]) begin
          e_addr = sa[g]; e_data = sd[g]; e_we = sw[g];
        end else begin
          e_addr = ma[g]; e_data = md[g]; e_we = mw[g];
        end
        sv[g] = 1'b0;
        if (ms[1-g] && !sv[1-g]) capture(1 - g);
        e_start = 1'b1; owner = g; last = g; age = 0;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic s0, input logic s1, input logic bd, input logic [31:0] q);
    ms[0] = s0; ms[1] = s1; bus_done = bd; bus_q = q;
    tick();
    ms[0] = 1'b0; ms[1] = 1'b0; bus_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    nreset = 1'b1;
    #1 nreset = 1'b0;
    ms[0] = 1'b1; ms[1] = 1'b1; bus_done = 1'b1; bus_q = 32'hFFFF_FFFF;
    #1 model_reset();
    check_all();
    repeat (2) @(negedge clk);
    ms[0] = 1'b0; ms[1] = 1'b0; bus_done = 1'b0; bus_q = '0;
    nreset = 1'b1;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      ms[n] = 1'b0; ma[n] = '0; md[n] = '0; mw[n] = 1'b0;
    end
    bus_done = 1'b0; bus_q = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(2);

    // Tie straight after reset: requester 0 first, requester 1 right after m0_done
    ma[0] = 27'h10; md[0] = 32'h1; mw[0] = 1'b0;
    ma[1] = 27'h20; md[1] = 32'h2; mw[1] = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("tie1_start", bus_start, 1'b1);
    chk("tie1_addr", bus_addr, 27'h10);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 32'hAAAA_0001);
    chk("tie1_m0_done", m0_done, 1'b1);
    idle(1);
    chk("tie1_m1_start", bus_start, 1'b1);
    chk("tie1_m1_addr", bus_addr, 27'h20);
    drive(1'b0, 1'b0, 1'b1, 32'hBBBB_0002);
    chk("tie1_m1_q", m1_q, 32'hBBBB_0002);

    // Single read, with a repeated start while granted
    ma[0] = 27'h0000100; md[0] = 32'h0; mw[0] = 1'b0;
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rd_start", bus_start, 1'b1);
    chk("rd_addr", bus_addr, 27'h0000100);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    chk("rd_done", m0_done, 1'b1);
    chk("rd_q", m0_q, 32'h1234_5678);
    idle(3);

    // Spurious bus_done in IDLE
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("spur_m0_done", m0_done, 1'b0);
    chk("spur_m0_q", m0_q, 32'h1234_5678);

    // Second tie after requester 0 was served last: requester 1 first
    ma[0] = 27'h30; ma[1] = 27'h40;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("tie2_addr", bus_addr, 27'h40);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    idle(1);
    chk("tie2_m0_addr", bus_addr, 27'h30);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0030);
    idle(2);

    // Write from requester 1
    ma[1] = 27'h1C00000; md[1] = 32'hA5A5_A5A5; mw[1] = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wr_we_issue", bus_we, 1'b1);
    chk("wr_data", bus_data, 32'hA5A5_A5A5);
    idle(2);
    chk("wr_we_wait", bus_we, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    chk("wr_we_idle", bus_we, 1'b0);
    chk("wr_m0_done", m0_done, 1'b0);
    idle(2);

    // Reset in the middle of WAIT, then a late bus_done
    ma[0] = 27'h55; md[0] = 32'h5555; mw[0] = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    idle(2);
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h7777_7777);
    chk("late_done", m0_done, 1'b0);
    chk("late_q", m0_q, 32'h0);
    idle(2);

    // No bus_done: abort after TO cycles when enabled, otherwise WAIT persists
    ma[0] = 27'h66; md[0] = 32'h6666; mw[0] = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      if (k == TO) begin
        chk("to_done", m0_done, TO_EN);
        chk("to_err", bus_err, TO_EN);
        chk("to_we", bus_we, !TO_EN);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_6666);
    idle(2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 2; n++) begin
        ma[n] = 27'($urandom);
        md[n] = $urandom;
        mw[n] = 1'($urandom_range(1));
      end
      drive(1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
            (owner >= 0) ? 1'($urandom_range(3) == 0) : 1'($urandom_range(15) == 0),
            $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 1023, WAIT-state cycles before abort (used only when BUS_ARBITER_TIMEOUT_EN is defined).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  system clock (50 MHz).
- nreset  in  1  asynchronous active-low reset.
- m0_addr  in  27  requester 0 (CPU) address.
- m0_data  in  32  requester 0 write data.
- m0_we  in  1  requester 0 write enable.
- m0_start  in  1  requester 0 request, one-cycle pulse.
- m0_q  out  32  requester 0 read data.
- m0_done  out  1  requester 0 completion, one-cycle pulse.
- m1_addr, m1_data, m1_we, m1_start, m1_q, m1_done  as m0_*, for requester 1 (DMA).
- bus_addr  out  27  MemoryUnit address.
- bus_data  out  32  MemoryUnit write data.
- bus_we  out  1  MemoryUnit write enable.
- bus_start  out  1  MemoryUnit start, one-cycle pulse.
- bus_q  in  32  MemoryUnit read data.
- bus_done  in  1  MemoryUnit completion pulse.
- bus_err  out  1  timeout-abort pulse.

Function
REQ-003 The block SHALL implement three states: IDLE, ISSUE, WAIT.
REQ-004 A start pulse on mN_start SHALL be captured with its addr/data/we into a per-requester pending slot; start SHALL be ignored while that requester's slot is pending or its transaction is granted.
REQ-005 In IDLE, the arbiter SHALL consider mN_start of the current cycle and pending slots together; if any request exists, it SHALL register the grant, drive bus_addr/bus_data/bus_we from the granted request, and enter ISSUE.
REQ-006 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; last_grant resets to 1 so requester 0 wins the first tie.
REQ-007 bus_start SHALL be 1 only in ISSUE (exactly one cycle); ISSUE SHALL go to WAIT unless bus_done is already high, in which case completion is taken immediately.
REQ-008 Latency: m0_start high in cycle N with an idle arbiter SHALL give bus_start high in cycle N+1.
REQ-009 bus_done in ISSUE or WAIT in cycle M SHALL register bus_q into the granted mN_q and pulse mN_done in cycle M+1; the state returns to IDLE, and a new grant may issue bus_start in cycle M+2.
REQ-010 bus_done in IDLE SHALL be ignored.
REQ-011 mN_q SHALL hold its value until that requester's next completion.
REQ-012 bus_addr/bus_data SHALL hold the last granted values in IDLE.
REQ-013 bus_we SHALL be 0 whenever the state is IDLE.
REQ-014 The non-granted requester's pending slot SHALL be preserved across the other's transaction and serviced next.

Reset
REQ-015 nreset low SHALL asynchronously force: state IDLE, pending slots clear, last_grant=1, bus_start=0, bus_we=0, bus_addr=0, bus_data=0, m0_q=m1_q=0, m0_done=m1_done=0, bus_err=0, timeout counter=0.
REQ-016 Reset mid-transaction SHALL abandon it silently, with no done pulse.
REQ-017 Starts sampled while nreset is low SHALL be discarded.

Configuration
REQ-018 With BUS_ARBITER_TIMEOUT_EN defined, a counter SHALL run in ISSUE/WAIT.
REQ-019 When that counter reaches TIMEOUT_CYCLES without bus_done, the block SHALL pulse the granted mN_done with mN_q=0, pulse bus_err for one cycle, and return to IDLE.
REQ-020 bus_done arriving after such an abort SHALL be ignored per REQ-010.
REQ-021 Without BUS_ARBITER_TIMEOUT_EN, no counter SHALL exist, bus_err SHALL be tied 0, and WAIT SHALL persist until bus_done.

Verification
REQ-022 Single read: m0_start at cycle 10 with m0_addr=0x0000100 and m0_we=0 -> bus_start at cycle 11 with bus_addr=0x0000100; bus_done at cycle 20 with bus_q=0x12345678 -> m0_done and m0_q=0x12345678 at cycle 21.
REQ-023 Tie: m0_start and m1_start in the same cycle after reset -> m0 is granted first, m1's bus_start follows m0_done+1, and a second simultaneous pair grants m1 first.
REQ-024 Write: m1 with addr=0x1C00000, data=0xA5A5A5A5, we=1 -> bus_we=1 in ISSUE/WAIT and 0 on return to IDLE; m0_done stays 0 throughout.
REQ-025 Ignored inputs: a repeated m0_start while granted produces no extra bus_start; a spurious bus_done in IDLE produces no done pulse.
REQ-026 Reset mid-WAIT: nreset low during WAIT -> all outputs take their REQ-015 values immediately, and a late bus_done after release is ignored.
REQ-027 Timeout (macro on, TIMEOUT_CYCLES=8, no bus_done) -> m0_done, m0_q=0 and bus_err pulse together 8 cycles after bus_start; with the macro off, the arbiter stays in WAIT.
